wb_port_arbiter: RTL

Round-robin arbiter that shares the two register-file write ports among four writeback requesters (integer pipes, load-store pipe, muldiv/trap). It sits between the execution-unit writeback stages and the register file. It grants up to two writes per cycle and serves high-priority requests first. It never grants two writes to the same destination in one cycle, and it retires x0-destination results without using a port. It also keeps the round-robin pointer and a registered per-cycle retire count for the trap/CSR unit.

---
 rtl/wb_port_arbiter.sv | 105 ++++++++++
 1 files changed

// File: rtl/wb_port_arbiter.sv
// Writeback arbiter: shares two register-file write ports among four requesters,
// high-priority first, round-robin within each priority, no same-cycle duplicate dst.
module wb_port_arbiter (
  input  logic         clk,
  input  logic         rst,
  input  logic [3:0]   req_valid,
  input  logic [3:0]   req_hipri,
  input  logic [19:0]  req_dst,
  input  logic [255:0] req_data,
  output logic [3:0]   req_ready,
  output logic         rf_wen0,
  output logic         rf_wen1,
  output logic [4:0]   rf_wdst0,
  output logic [4:0]   rf_wdst1,
  output logic [63:0]  rf_wdata0,
  output logic [63:0]  rf_wdata1,
  output logic [2:0]   wb_retire_cnt
);

  logic [1:0] ptr_q, ptr_d;
  logic [2:0] retire_cnt_q, retire_cnt_d;
  logic [1:0] gnt0_idx, gnt1_idx;

  always_comb begin : grant_logic
    logic [1:0] idx;
    logic [4:0] dst;
    logic       hi;
    req_ready = '0;
    rf_wen0   = 1'b0;
    rf_wen1   = 1'b0;
    rf_wdst0  = '0;
    rf_wdst1  = '0;
    rf_wdata0 = '0;
    rf_wdata1 = '0;
    gnt0_idx  = '0;
    gnt1_idx  = '0;
    idx       = '0;
    dst       = '0;
    hi        = 1'b0;
    // Pass 0 serves hipri requests, pass 1 the rest; both walk from ptr_q.
    for (int p = 0; p < 2; p++) begin
      hi = (p == 0);
      for (int k = 0; k < 4; k++) begin
        idx = ptr_q + 2'(k);
        dst = req_dst[5*idx +: 5];
        if (req_valid[idx] && (dst != '0) && (req_hipri[idx] == hi)) begin
          if (!rf_wen0) begin
            rf_wen0        = 1'b1;
            rf_wdst0       = dst;
            rf_wdata0      = req_data[64*idx +: 64];
            gnt0_idx       = idx;
            req_ready[idx] = 1'b1;
          end else if (!rf_wen1 && (dst != rf_wdst0)) begin
            rf_wen1        = 1'b1;
            rf_wdst1       = dst;
            rf_wdata1      = req_data[64*idx +: 64];
            gnt1_idx       = idx;
            req_ready[idx] = 1'b1;
          end
        end
      end
    end
    // x0 writes retire without a port.
    for (int i = 0; i < 4; i++) begin
      if (req_valid[i] && (req_dst[5*i +: 5] == '0)) begin
        req_ready[i] = 1'b1;
      end
    end
    if (rst) begin
      req_ready = '0;
      rf_wen0   = 1'b0;
      rf_wen1   = 1'b0;
      rf_wdst0  = '0;
      rf_wdst1  = '0;
      rf_wdata0 = '0;
      rf_wdata1 = '0;
    end
  end

  always_comb begin
    ptr_d = ptr_q;
    if (rf_wen1) begin
      ptr_d = gnt1_idx + 2'd1;
    end else if (rf_wen0) begin
      ptr_d = gnt0_idx + 2'd1;
    end
    retire_cnt_d = '0;
    for (int i = 0; i < 4; i++) begin
      retire_cnt_d = retire_cnt_d + 3'(req_valid[i] & req_ready[i]);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ptr_q        <= '0;
      retire_cnt_q <= '0;
    end else begin
      ptr_q        <= ptr_d;
      retire_cnt_q <= retire_cnt_d;
    end
  end

  assign wb_retire_cnt = retire_cnt_q;

endmodule
